alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: EXEC_CYCLES, default 1, ALU settle cycles in EXEC state (legal 1..15).
REQ-002 Parameter: OP_W, default 3, opcode width.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request new operation; sampled only in IDLE.
REQ-006 Port: op_in  input  OP_W  opcode captured with start.
REQ-007 Port: data_valid  input  1  operand present on external bus this cycle.
REQ-008 Port: abort  input  1  cancel operation in progress.
REQ-009 Port: data_ready  output  1  sequencer accepts an operand this cycle.
REQ-010 Port: ld_a  output  1  load enable, operand-A 8-bit register.
REQ-011 Port: ld_b  output  1  load enable, operand-B 8-bit register.
REQ-012 Port: ld_r  output  1  load enable, result 8-bit register.
REQ-013 Port: alu_op  output  OP_W  opcode driven to ALU, held stable from capture until return to IDLE.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse, result register written.
REQ-016 Port: op_count  output  16  completed-operation count (see Configuration).

Function
REQ-017 States SHALL be IDLE, WAIT_A, WAIT_B, EXEC, WRITE, DONE; encoding free.
REQ-018 IDLE: start=1 -> WAIT_A, op_in captured into alu_op same edge; start=0 -> stay.
REQ-019 WAIT_A: data_ready=1; ld_a = data_valid (combinational); data_valid=1 -> WAIT_B.
REQ-020 WAIT_B: data_ready=1; ld_b = data_valid (combinational); data_valid=1 -> EXEC, exec counter loaded EXEC_CYCLES-1.
REQ-021 EXEC: counter decrements each cycle; at 0 -> WRITE; dwell exactly EXEC_CYCLES cycles.
REQ-022 WRITE: ld_r=1 for exactly one cycle -> DONE.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE; start in DONE ignored.
REQ-024 Latency start to done, with data_valid held high: EXEC_CYCLES+4 cycles.
REQ-025 data_ready, ld_a, ld_b SHALL be 0 outside WAIT_A/WAIT_B; data_valid elsewhere ignored.
REQ-026 ld_a, ld_b, ld_r SHALL be mutually exclusive (never two high same cycle).
REQ-027 start while busy=1 SHALL be ignored, no queuing.
REQ-028 abort in WAIT_A, WAIT_B or EXEC -> IDLE next edge; no ld_r, no done, op_count unchanged.
REQ-029 abort in WRITE or DONE ignored; operation completes.
REQ-030 abort and data_valid same cycle in WAIT_x: abort wins, ld_x still asserted that cycle (combinational), state -> IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, independent of clk.
REQ-032 Reset values: busy=0, done=0, ld_a=0, ld_b=0, ld_r=0, data_ready=0, alu_op=0, exec counter=0, op_count=0.
REQ-033 Reset mid-operation SHALL discard operation with no ld_r or done pulse; first start after deassertion accepted on first rising edge with rst_n=1.

Configuration
REQ-034 Macro ALU_SEQ_OPCNT_EN defined: op_count increments by 1 on each cycle done=1, saturates at 16'hFFFF.
REQ-035 Macro ALU_SEQ_OPCNT_EN undefined: op_count port present, tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-036 Reset, start=1 op_in=3'b010, data_valid held 1, EXEC_CYCLES=1 -> ld_a cycle 1, ld_b cycle 2, ld_r cycle 4, done cycle 5, alu_op=3'b010 throughout, busy cycles 1-5.
REQ-037 EXEC_CYCLES=4, data_valid asserted 3 cycles late for A and 2 late for B -> ld_a/ld_b each single-cycle at valid, EXEC dwell exactly 4 cycles, done one cycle after ld_r.
REQ-038 start pulsed while busy with op_in=3'b111 -> alu_op unchanged, exactly one done; abort asserted in EXEC -> no ld_r, no done, busy=0 next cycle.
REQ-039 rst_n driven low mid-cycle in WAIT_B -> busy, data_ready, alu_op go 0 before next clk edge; no done follows.
REQ-040 With ALU_SEQ_OPCNT_EN: 3 completed ops + 1 aborted -> op_count=3; preloaded near 16'hFFFE, 3 ops -> 16'hFFFF held; without macro op_count=0 always.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control FSM for a two-operand ALU datapath.
// Ports: clk, rst_n (async low) | start, op_in, data_valid, abort in
//   | data_ready, ld_a, ld_b, ld_r, alu_op, busy, done, op_count out.
// Option: define ALU_SEQ_OPCNT_EN to build the saturating op_count;
//   otherwise op_count is tied to zero and has no flops.
module alu_sequencer #(
   parameter int EXEC_CYCLES = 1,
   parameter int OP_W        = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OP_W-1:0] op_in,
   input  logic            data_valid,
   input  logic            abort,
   output logic            data_ready,
   output logic            ld_a,
   output logic            ld_b,
   output logic            ld_r,
   output logic [OP_W-1:0] alu_op,
   output logic            busy,
   output logic            done,
   output logic [15:0]     op_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_A,
      S_WAIT_B,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [OP_W-1:0]   r_alu_op;
   logic              w_rdy;
   logic              w_ld_a;
   logic              w_ld_b;
   logic              w_ld_r;
   logic              w_done;
   logic              w_capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_alu_op <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         if (w_capture)
            r_alu_op <= op_in;
      end
   end

   // ld_a/ld_b follow data_valid combinationally, so an operand
   // offered in the same cycle as abort is still latched.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_rdy     = 1'b0;
      w_ld_a    = 1'b0;
      w_ld_b    = 1'b0;
      w_ld_r    = 1'b0;
      w_done    = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next    = S_WAIT_A;
               w_capture = 1'b1;
            end
         end
         S_WAIT_A: begin
            w_rdy  = 1'b1;
            w_ld_a = data_valid;
            if (abort)
               w_next = S_IDLE;
            else if (data_valid)
               w_next = S_WAIT_B;
         end
         S_WAIT_B: begin
            w_rdy  = 1'b1;
            w_ld_b = data_valid;
            if (abort) begin
               w_next = S_IDLE;
            end else if (data_valid) begin
               w_next    = S_EXEC;
               w_cnt_nxt = EXEC_LOAD;
            end
         end
         S_EXEC: begin
            if (abort)
               w_next = S_IDLE;
            else if (r_cnt == 4'd0)
               w_next = S_WRITE;
            else
               w_cnt_nxt = r_cnt - 4'd1;
         end
         S_WRITE: begin
            w_ld_r = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign data_ready = w_rdy;
   assign ld_a       = w_ld_a;
   assign ld_b       = w_ld_b;
   assign ld_r       = w_ld_r;
   assign done       = w_done;
   assign alu_op     = r_alu_op;
   assign busy       = (r_state != S_IDLE);

`ifdef ALU_SEQ_OPCNT_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_op_count <= '0;
      else if (w_done && (r_op_count != 16'hFFFF))
         r_op_count <= r_op_count + 16'd1;
   end

   assign op_count = r_op_count;
`else
   assign op_count = '0;
`endif

endmodule
